byte_ram_sync: RTL and testbench
================================

// Module: byte_ram_sync
// PURPOSE
//  Parametrised byte-enabled synchronous RAM with one write port and one read port, used as data/scratch memory in the CPU.
//  Successor to the 4KB asynchronous-write RAM: registered reads with a valid strobe, optional output register,
//  per-byte write-first forwarding, hardware clear after reset, and out-of-range address detection.
// PARAMETERS
//  DATA_W          32    word width in bits; must be a multiple of 8; BYTES = DATA_W/8
//  DEPTH           1024  words; power of two; IDX_W = log2(DEPTH), OFF_W = log2(BYTES)
//  ADDR_W          32    byte-address width on both ports
//  OUT_REG         0     1 = extra output register; read latency = 1 + OUT_REG
//  CLEAR_ON_RESET  1     1 = zero every word after reset before accepting traffic
//  CHECK_RANGE     1     1 = flag and suppress accesses with addr[ADDR_W-1:OFF_W+IDX_W] != 0
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  resetn     in   1        asynchronous active-low reset
//  init_done  out  1        1 = clear finished, ports accepting requests
//  wr_en      in   1        write request
//  wr_sel     in   BYTES    byte enables; bit i writes wr_data[8i+7:8i]
//  wr_addr    in   ADDR_W   byte address; word index = wr_addr[OFF_W+IDX_W-1:OFF_W]
//  wr_data    in   DATA_W   write data
//  rd_en      in   1        read request
//  rd_addr    in   ADDR_W   byte address; same index rule as wr_addr
//  rd_data    out  DATA_W   read data, qualified by rd_valid
//  rd_valid   out  1        one-cycle pulse per accepted read
//  rd_err     out  1        with rd_valid: read was out of range, rd_data = 0
//  wr_err     out  1        one-cycle pulse: accepted write was out of range, suppressed
// BEHAVIOUR
//  Reset (resetn=0, async): rd_data=0, rd_valid=0, rd_err=0, wr_err=0, init_done=0, clr_idx=0,
//   FSM -> CLEAR if CLEAR_ON_RESET else READY. Array contents untouched by reset itself.
//  FSM states:
//   CLEAR: each edge writes 0 to word clr_idx, clr_idx++. At clr_idx == DEPTH-1, write it, go READY.
//    wr_en/rd_en ignored: no write, no rd_valid, no err pulses.
//   READY: init_done=1 (registered; high from first READY cycle). No exit except reset.
//  Reset in CLEAR restarts at clr_idx=0. init_done rises exactly DEPTH edges after resetn deasserts.
//  Write (READY, wr_en=1, in range): on edge, bytes with wr_sel[i]=1 updated; others kept.
//   wr_sel=0 is a legal no-op.
//  Read (READY, rd_en=1): array sampled on the request edge. rd_data/rd_valid appear
//   1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1). Back-to-back reads every cycle allowed.
//  rd_valid=0 cycles: rd_data holds its last value.
//  Read-during-write, same word index, same edge: per byte, write-first.
//   wr_sel[i]=1 -> new byte returned; else old byte.
//   A write landing while the read sits in the OUT_REG stage is not forwarded.
//  Range (CHECK_RANGE=1): nonzero upper bits on a write -> no array change, wr_err pulses next cycle.
//   On a read -> rd_data=0, rd_err=1 with rd_valid.
//   CHECK_RANGE=0: upper bits ignored (address wraps), err outputs tied 0.
//  Low OFF_W address bits ignored on both ports.
//  Array: BYTES byte-lanes of DEPTH x 8, inferable as block RAM with byte write enables.
//   No combinational read path.
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=1024: pulse resetn -> init_done=0 for 1024 edges then 1.
//    rd_en during clear gives no rd_valid; read 0x3FC after -> 0.
//  2 Write 0x11223344 @0x10 sel=1111, then sel=0010 data 0xAABBCCDD -> read 0x10 returns 0x1122CC44, 1 cycle later.
//  3 Same-edge wr 0x20 sel=1001 data 0xFFFFFFFF over 0x01020304, rd 0x20 -> rd_data 0xFF0203FF.
//  4 OUT_REG=1: reads @0x0,0x4,0x8 on 3 consecutive edges -> rd_valid 3 consecutive cycles starting 2 after first.
//    Data in order.
//  5 CHECK_RANGE=1: wr 0x1000 data 0xDEAD -> wr_err pulse, word 0 unchanged.
//    rd 0x1000 -> rd_valid=1, rd_err=1, rd_data=0.
//  6 resetn low at clr_idx=500 for 1 cycle -> clear restarts; init_done rises 1024 edges after release.

Source files
------------

// File: rtl/byte_ram_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : byte_ram_sync                                                 |
// | Purpose  : Byte-enabled synchronous RAM, one write and one read port,    |
// |            registered reads with valid strobe, optional output stage,    |
// |            per-byte write-first forwarding, post-reset hardware clear    |
// |            and out-of-range address detection.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module byte_ram_sync #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 1024,
   parameter int ADDR_W         = 32,
   parameter bit OUT_REG        = 1'b0,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter bit CHECK_RANGE    = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   output logic                  init_done,
   input  logic                  wr_en,
   input  logic [DATA_W/8-1:0]   wr_sel,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   output logic                  wr_err
);

   localparam int BYTES  = DATA_W / 8;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int OFF_W  = $clog2(BYTES);
   localparam int HI_LSB = OFF_W + IDX_W;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
   logic                init_done_q, init_done_d;
   logic                wr_err_q, wr_err_d;
   logic                s1_valid_q, s1_valid_d;
   logic                s1_err_q, s1_err_d;
   logic                s1_ok_q, s1_ok_d;

   logic [IDX_W-1:0]    w_wr_idx, w_rd_idx, w_mem_idx;
   logic                w_wr_oor, w_rd_oor;
   logic                w_ready, w_wr_acc, w_rd_acc, w_rd_ok, w_same_idx;
   logic [BYTES-1:0]    w_mem_we;
   logic [DATA_W-1:0]   w_mem_wdata;
   logic [DATA_W-1:0]   w_raw;
   logic [DATA_W-1:0]   w_s1_data;
   logic                w_unused_addr;

   // Byte-offset bits never select anything; upper bits only matter when range checking
   assign w_unused_addr = ^{wr_addr, rd_addr};

   assign w_wr_idx = wr_addr[HI_LSB-1:OFF_W];
   assign w_rd_idx = rd_addr[HI_LSB-1:OFF_W];

   if (CHECK_RANGE && (ADDR_W > HI_LSB)) begin : g_range_chk
      assign w_wr_oor = |wr_addr[ADDR_W-1:HI_LSB];
      assign w_rd_oor = |rd_addr[ADDR_W-1:HI_LSB];
   end else begin : g_range_off
      assign w_wr_oor = 1'b0;
      assign w_rd_oor = 1'b0;
   end

   assign w_ready    = (state_q == ST_READY);
   assign w_wr_acc   = w_ready & wr_en & ~w_wr_oor;
   assign w_rd_acc   = w_ready & rd_en;
   assign w_rd_ok    = w_rd_acc & ~w_rd_oor;
   assign w_same_idx = (w_wr_idx == w_rd_idx);

   // Clear sequencer next state; init_done tracks the state being entered
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == ST_CLEAR) begin
         clr_idx_d = clr_idx_q + IDX_W'(1);
         if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
            state_d = ST_READY;
         end
      end
      init_done_d = (state_d == ST_READY);
   end

   // Array write port: the clear sequencer owns it until the memory is zeroed
   always_comb begin
      w_mem_idx   = w_wr_idx;
      w_mem_wdata = wr_data;
      w_mem_we    = '0;
      if (state_q == ST_CLEAR) begin
         w_mem_idx   = clr_idx_q;
         w_mem_wdata = '0;
         w_mem_we    = '1;
      end else if (w_wr_acc) begin
         w_mem_we = wr_sel;
      end
   end

   // Read-stage control; s1_ok remembers whether the held data is real or an error zero
   always_comb begin
      s1_valid_d = w_rd_acc;
      s1_err_d   = w_rd_acc & w_rd_oor;
      s1_ok_d    = w_rd_acc ? ~w_rd_oor : s1_ok_q;
      wr_err_d   = w_ready & wr_en & w_wr_oor;
   end

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_q, rd_byte_d;

      // Write-first: a same-edge write to this byte lane overrides the stored byte
      always_comb begin
         rd_byte_d = mem[w_rd_idx];
         if (w_wr_acc && w_same_idx && wr_sel[i]) begin
            rd_byte_d = wr_data[8*i +: 8];
         end
      end

      // Byte-lane storage, no reset so it maps onto block RAM
      always_ff @(posedge clk) begin
         if (w_mem_we[i]) begin
            mem[w_mem_idx] <= w_mem_wdata[8*i +: 8];
         end
      end

      // Synchronous read register, only loaded by accepted in-range reads
      always_ff @(posedge clk) begin
         if (w_rd_ok) begin
            rd_byte_q <= rd_byte_d;
         end
      end

      assign w_raw[8*i +: 8] = rd_byte_q;
   end

   assign w_s1_data = s1_ok_q ? w_raw : '0;

   // Control and status flops
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_idx_q   <= '0;
         init_done_q <= 1'b0;
         wr_err_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_err_q    <= 1'b0;
         s1_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_idx_q   <= clr_idx_d;
         init_done_q <= init_done_d;
         wr_err_q    <= wr_err_d;
         s1_valid_q  <= s1_valid_d;
         s1_err_q    <= s1_err_d;
         s1_ok_q     <= s1_ok_d;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic [DATA_W-1:0] out_data_q, out_data_d;
      logic              out_valid_q, out_err_q;

      // Output register loads only with a valid first stage so data holds otherwise
      always_comb begin
         out_data_d = s1_valid_q ? w_s1_data : out_data_q;
      end

      // Second read pipeline stage
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
         end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= s1_valid_q;
            out_err_q   <= s1_err_q;
         end
      end

      assign rd_data  = out_data_q;
      assign rd_valid = out_valid_q;
      assign rd_err   = out_err_q;
   end else begin : g_no_out_reg
      assign rd_data  = w_s1_data;
      assign rd_valid = s1_valid_q;
      assign rd_err   = s1_err_q;
   end

   assign init_done = init_done_q;
   assign wr_err    = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_ram_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_byte_ram_sync                                              |
// | Purpose  : Directed self-checking bench for byte_ram_sync, one instance  |
// |            without and one with the output register.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_byte_ram_sync;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wr_en, rd_en;
   logic [3:0]  wr_sel;
   logic [31:0] wr_addr, wr_data, rd_addr;

   logic        init_done, rd_valid, rd_err, wr_err;
   logic [31:0] rd_data;
   logic        init_done2, rd_valid2, rd_err2, wr_err2;
   logic [31:0] rd_data2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   byte_ram_sync #(
      .DATA_W(32), .DEPTH(1024), .ADDR_W(32),
      .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .CHECK_RANGE(1'b1)
   ) dut (
      .clk(clk), .resetn(resetn), .init_done(init_done),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_err(rd_err), .wr_err(wr_err)
   );

   byte_ram_sync #(
      .DATA_W(32), .DEPTH(1024), .ADDR_W(32),
      .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .CHECK_RANGE(1'b1)
   ) dut_oreg (
      .clk(clk), .resetn(resetn), .init_done(init_done2),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
      .rd_valid(rd_valid2), .rd_err(rd_err2), .wr_err(wr_err2)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      wr_sel = 4'h0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = a;
      wr_data = d;
      tick();
      idle();
   endtask

   // Counts edges until init_done rises, bounded
   task automatic count_clear(output int n, output logic seen);
      n    = 0;
      seen = 1'b0;
      while (init_done !== 1'b1 && n < 3000) begin
         tick();
         n++;
         if (rd_valid === 1'b1 || wr_err === 1'b1 || rd_valid2 === 1'b1) seen = 1'b1;
      end
   endtask

   initial begin
      int   n;
      logic seen;

      resetn  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      idle();
      tick();
      tick();

      // Reset state
      check_eq("rst_init_done", init_done, 0);
      check_eq("rst_rd_valid", rd_valid, 0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_wr_err", wr_err, 0);
      check_eq("rst_oreg_data", rd_data2, 0);

      // Clear sequence with traffic that must be ignored
      wr_en   = 1'b1;
      wr_sel  = 4'hF;
      wr_addr = 32'h3FC;
      wr_data = 32'hFFFF_FFFF;
      rd_en   = 1'b1;
      rd_addr = 32'h3FC;
      resetn  = 1'b1;
      count_clear(n, seen);
      idle();
      check_eq("clear_edges", n, 1024);
      check_eq("clear_no_strobe", seen, 0);
      check_eq("clear_oreg_done", init_done2, 1);

      rd_en   = 1'b1;
      rd_addr = 32'h3FC;
      tick();
      idle();
      check_eq("post_clear_valid", rd_valid, 1);
      check_eq("post_clear_data", rd_data, 0);

      // Byte-enable merge
      do_write(32'h10, 4'b1111, 32'h1122_3344);
      check_eq("wr_ok_no_err", wr_err, 0);
      do_write(32'h10, 4'b0010, 32'hAABB_CCDD);
      rd_en   = 1'b1;
      rd_addr = 32'h10;
      tick();
      idle();
      check_eq("merge_valid", rd_valid, 1);
      check_eq("merge_data", rd_data, 32'h1122_CC44);
      tick();
      check_eq("idle_valid", rd_valid, 0);
      check_eq("idle_hold", rd_data, 32'h1122_CC44);

      // Same-edge read and write, per-byte write-first
      do_write(32'h20, 4'b1111, 32'h0102_0304);
      wr_en   = 1'b1;
      wr_sel  = 4'b1001;
      wr_addr = 32'h20;
      wr_data = 32'hFFFF_FFFF;
      rd_en   = 1'b1;
      rd_addr = 32'h20;
      tick();
      idle();
      check_eq("fwd_data", rd_data, 32'hFF02_03FF);
      rd_en   = 1'b1;
      rd_addr = 32'h23;
      tick();
      idle();
      check_eq("low_bits_ignored", rd_data, 32'hFF02_03FF);

      // Pipelined reads through the output register
      do_write(32'h0, 4'hF, 32'hCAFE_0000);
      do_write(32'h4, 4'hF, 32'hCAFE_0004);
      do_write(32'h8, 4'hF, 32'hCAFE_0008);
      rd_en   = 1'b1;
      rd_addr = 32'h0;
      tick();
      check_eq("b2b_direct_data", rd_data, 32'hCAFE_0000);
      check_eq("oreg_lat_valid0", rd_valid2, 0);
      rd_addr = 32'h4;
      tick();
      check_eq("oreg_valid1", rd_valid2, 1);
      check_eq("oreg_data1", rd_data2, 32'hCAFE_0000);
      rd_addr = 32'h8;
      tick();
      idle();
      check_eq("oreg_valid2", rd_valid2, 1);
      check_eq("oreg_data2", rd_data2, 32'hCAFE_0004);
      tick();
      check_eq("oreg_valid3", rd_valid2, 1);
      check_eq("oreg_data3", rd_data2, 32'hCAFE_0008);
      tick();
      check_eq("oreg_valid_end", rd_valid2, 0);
      check_eq("oreg_hold", rd_data2, 32'hCAFE_0008);

      // Out-of-range write and read
      do_write(32'h1000, 4'hF, 32'h0000_DEAD);
      check_eq("wr_err_pulse", wr_err, 1);
      tick();
      check_eq("wr_err_clear", wr_err, 0);
      rd_en   = 1'b1;
      rd_addr = 32'h1000;
      tick();
      idle();
      check_eq("oor_rd_valid", rd_valid, 1);
      check_eq("oor_rd_err", rd_err, 1);
      check_eq("oor_rd_data", rd_data, 0);
      rd_en   = 1'b1;
      rd_addr = 32'h0;
      tick();
      idle();
      check_eq("word0_err", rd_err, 0);
      check_eq("word0_kept", rd_data, 32'hCAFE_0000);

      // Reset in the middle of clearing restarts the sequence
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 500; i++) tick();
      check_eq("mid_clear_busy", init_done, 0);
      resetn = 1'b0;
      tick();
      check_eq("mid_reset_done", init_done, 0);
      resetn = 1'b1;
      count_clear(n, seen);
      check_eq("restart_edges", n, 1024);
      rd_en   = 1'b1;
      rd_addr = 32'h0;
      tick();
      idle();
      check_eq("recleared_valid", rd_valid, 1);
      check_eq("recleared_data", rd_data, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
